// File: rtl/bellman_ford_engine_pkg.sv
// Shared types and arithmetic helpers for the Bellman-Ford relaxation engine.
// Widths up to 62 bits are supported by the 64-bit helper arithmetic.
package bf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RELAX,
    ST_CHECK,
    ST_DONE
  } bf_state_e;

  // Largest positive value of a signed w-bit quantity; marks "no edge" / "unreached".
  function automatic logic signed [63:0] bf_inf(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Saturating add clamped to [signed min, INF-1] so a relaxed distance never
  // collides with INF and never wraps. Operands are sign-extended w-bit values,
  // so the 64-bit sum is exact (equivalent to a w+1 bit sum).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = bf_inf(w) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/bellman_ford_engine_if.sv
// Control, matrix-read and readout signals of the Bellman-Ford engine.
// slave: engine side; master: host / memory side.
interface bellman_ford_engine_if #(
  parameter int NODES    = 16,
  parameter int LANES    = 4,
  parameter int WEIGHT_W = 32
);
  localparam int IDX_W = $clog2(NODES);

  logic                        start;
  logic [IDX_W-1:0]            src;
  logic                        adj_rd_en;
  logic [IDX_W-1:0]            adj_row;
  logic [IDX_W-1:0]            adj_col;
  logic [LANES*WEIGHT_W-1:0]   adj_rd_data;
  logic [IDX_W-1:0]            dist_rd_addr;
  logic signed [WEIGHT_W-1:0]  dist_rd_data;
  logic [IDX_W-1:0]            pred_rd_data;
  logic                        busy;
  logic                        done;
  logic                        neg_cycle;
  logic [IDX_W-1:0]            neg_node;

  modport slave (
    input  start, src, adj_rd_data, dist_rd_addr,
    output adj_rd_en, adj_row, adj_col, dist_rd_data, pred_rd_data,
           busy, done, neg_cycle, neg_node
  );

  modport master (
    output start, src, adj_rd_data, dist_rd_addr,
    input  adj_rd_en, adj_row, adj_col, dist_rd_data, pred_rd_data,
           busy, done, neg_cycle, neg_node
  );
endinterface

// File: rtl/bellman_ford_engine_relax_lane.sv
// One relaxation lane: decides whether edge weight w improves dist[v] via u.
module bf_relax_lane
  import bf_pkg::*;
#(
  parameter int WEIGHT_W = 32
) (
  input  logic signed [WEIGHT_W-1:0] du_i,
  input  logic signed [WEIGHT_W-1:0] w_i,
  input  logic signed [WEIGHT_W-1:0] dv_i,
  output logic                       relax_o,
  output logic signed [WEIGHT_W-1:0] new_d_o
);
  localparam logic signed [WEIGHT_W-1:0] INF = WEIGHT_W'(bf_inf(WEIGHT_W));

  // Saturated candidate distance and strict-improvement test.
  always_comb begin
    new_d_o = WEIGHT_W'(sat_add(64'(du_i), 64'(w_i), WEIGHT_W));
    relax_o = (du_i != INF) && (w_i != INF) && (new_d_o < dv_i);
  end
endmodule

// File: rtl/bellman_ford_engine.sv
// Bellman-Ford single-source shortest-path engine with negative-cycle check.
// Streams the weight matrix LANES edges per cycle: issue read, relax next cycle.
// Optional macro BF_EARLY_EXIT_EN: finish as soon as a relax sweep makes no update.
module bellman_ford_engine
  import bf_pkg::*;
#(
  parameter int NODES    = 16,
  parameter int LANES    = 4,
  parameter int WEIGHT_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  bellman_ford_engine_if.slave bus
);
  localparam int IDX_W = $clog2(NODES);
  localparam logic signed [WEIGHT_W-1:0] INF = WEIGHT_W'(bf_inf(WEIGHT_W));
  localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(NODES - 1);
  localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(NODES - LANES);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(NODES - 2);
  localparam logic [IDX_W-1:0] STEP      = IDX_W'(LANES);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

  bf_state_e state_q, state_d;

  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic [IDX_W-1:0] neg_node_q, neg_node_d;
  logic             drain_q, drain_d;
  logic             neg_cycle_q, neg_cycle_d;
  logic             rd_vld_q;
  logic [IDX_W-1:0] rd_row_q;
  logic [IDX_W-1:0] rd_col_q;

  logic signed [WEIGHT_W-1:0] dist_q [NODES];
  logic signed [WEIGHT_W-1:0] dist_d [NODES];
  logic [IDX_W-1:0]           pred_q [NODES];
  logic [IDX_W-1:0]           pred_d [NODES];

  logic [LANES-1:0]           lane_relax;
  logic signed [WEIGHT_W-1:0] lane_new [LANES];

  logic rd_en;
  logic last_addr;
  logic any_relax;

`ifdef BF_EARLY_EXIT_EN
  logic upd_q, upd_d;
  logic sweep_upd;
  assign sweep_upd = upd_q | any_relax;
`endif

  assign last_addr = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign any_relax = rd_vld_q && (|lane_relax);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bf_relax_lane #(.WEIGHT_W(WEIGHT_W)) u_lane (
      .du_i   (dist_q[rd_row_q]),
      .w_i    (bus.adj_rd_data[k*WEIGHT_W +: WEIGHT_W]),
      .dv_i   (dist_q[rd_col_q + IDX_W'(k)]),
      .relax_o(lane_relax[k]),
      .new_d_o(lane_new[k])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: sweeps end on their drain cycle (drain_q).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) state_d = ST_INIT;
      ST_INIT:          state_d = ST_RELAX;
      ST_RELAX: begin
        if (drain_q) begin
`ifdef BF_EARLY_EXIT_EN
          if (!sweep_upd) state_d = ST_DONE;
          else
`endif
          if (pass_q == LAST_PASS) state_d = ST_CHECK;
        end
      end
      ST_CHECK:         if (drain_q) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs: read strobe and handshake.
  always_comb begin
    rd_en    = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      ST_INIT:            bus.busy = 1'b1;
      ST_RELAX, ST_CHECK: begin
        bus.busy = 1'b1;
        rd_en    = !drain_q;
      end
      ST_DONE:            bus.done = 1'b1;
      default:            ;
    endcase
  end

  assign bus.adj_rd_en    = rd_en;
  assign bus.adj_row      = row_q;
  assign bus.adj_col      = col_q;
  assign bus.dist_rd_data = dist_q[bus.dist_rd_addr];
  assign bus.pred_rd_data = pred_q[bus.dist_rd_addr];
  assign bus.neg_cycle    = neg_cycle_q;
  assign bus.neg_node     = neg_node_q;

  // Datapath next-state: address walk, relax writes, check-pass capture.
  // The read address only moves on edges into or out of an issue cycle, so it
  // stays put through drain, INIT and DONE.
  always_comb begin
    logic found;
    found       = 1'b0;
    src_d       = src_q;
    row_d       = row_q;
    col_d       = col_q;
    pass_d      = pass_q;
    drain_d     = drain_q;
    neg_cycle_d = neg_cycle_q;
    neg_node_d  = neg_node_q;
    dist_d      = dist_q;
    pred_d      = pred_q;
`ifdef BF_EARLY_EXIT_EN
    upd_d       = upd_q;
`endif

    if ((state_q == ST_IDLE || state_q == ST_DONE) && bus.start) src_d = bus.src;

    if (state_q == ST_INIT) begin
      row_d       = '0;
      col_d       = '0;
      pass_d      = '0;
      drain_d     = 1'b0;
      neg_cycle_d = 1'b0;
      neg_node_d  = '0;
`ifdef BF_EARLY_EXIT_EN
      upd_d       = 1'b0;
`endif
      for (int unsigned i = 0; i < NODES; i++) begin
        dist_d[i] = (IDX_W'(i) == src_q) ? '0 : INF;
        pred_d[i] = '0;
      end
    end

    if (rd_en) begin
      if (last_addr)              drain_d = 1'b1;
      else if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + ONE;
      end
      else                        col_d = col_q + STEP;
    end

    if (rd_vld_q && state_q == ST_RELAX) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (lane_relax[k]) begin
          dist_d[rd_col_q + IDX_W'(k)] = lane_new[k];
          pred_d[rd_col_q + IDX_W'(k)] = rd_row_q;
        end
      end
`ifdef BF_EARLY_EXIT_EN
      upd_d = upd_q | (|lane_relax);
`endif
    end

    if (rd_vld_q && state_q == ST_CHECK && !neg_cycle_q) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (lane_relax[k] && !found) begin
          found       = 1'b1;
          neg_cycle_d = 1'b1;
          neg_node_d  = rd_col_q + IDX_W'(k);
        end
      end
    end

    if (drain_q && (state_q == ST_RELAX || state_q == ST_CHECK)) begin
      drain_d = 1'b0;
`ifdef BF_EARLY_EXIT_EN
      upd_d   = 1'b0;
`endif
      if (state_q == ST_RELAX) pass_d = pass_q + ONE;
      if (state_d == ST_RELAX || state_d == ST_CHECK) begin
        row_d = '0;
        col_d = '0;
      end
    end
  end

  // Datapath registers and the one-cycle read pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pass_q      <= '0;
      drain_q     <= 1'b0;
      neg_cycle_q <= 1'b0;
      neg_node_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
`ifdef BF_EARLY_EXIT_EN
      upd_q       <= 1'b0;
`endif
      for (int unsigned i = 0; i < NODES; i++) begin
        dist_q[i] <= INF;
        pred_q[i] <= '0;
      end
    end else begin
      src_q       <= src_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pass_q      <= pass_d;
      drain_q     <= drain_d;
      neg_cycle_q <= neg_cycle_d;
      neg_node_q  <= neg_node_d;
      rd_vld_q    <= rd_en;
      if (rd_en) begin
        rd_row_q <= row_q;
        rd_col_q <= col_q;
      end
`ifdef BF_EARLY_EXIT_EN
      upd_q       <= upd_d;
`endif
      dist_q      <= dist_d;
      pred_q      <= pred_d;
    end
  end
endmodule

// File: tb/tb_bellman_ford_engine.sv
// Bench for bellman_ford_engine: directed graphs plus random graphs checked
// against a plain Bellman-Ford sweep model (honours BF_EARLY_EXIT_EN).
module tb_bellman_ford_engine;
  localparam int N   = 4;
  localparam int L   = 2;
  localparam int W   = 32;
  localparam int IDX = $clog2(N);
  localparam longint INF  = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));
`ifdef BF_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bellman_ford_engine_if #(.NODES(N), .LANES(L), .WEIGHT_W(W)) bus ();

  bellman_ford_engine #(.NODES(N), .LANES(L), .WEIGHT_W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Weight memory: data for the address presented with adj_rd_en appears next cycle.
  longint adj [N][N];
  always @(posedge clk) begin
    if (bus.adj_rd_en)
      for (int k = 0; k < L; k++)
        bus.adj_rd_data[k*W +: W] <= W'(adj[bus.adj_row][int'(bus.adj_col) + k]);
  end

  // Read-address hygiene: no movement while the strobe is low, column aligned.
  logic [IDX-1:0] prev_row, prev_col;
  int viol = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.adj_rd_en && (bus.adj_row != prev_row || bus.adj_col != prev_col)) viol++;
      if ((int'(bus.adj_col) % L) != 0) viol++;
    end
    prev_row = bus.adj_row;
    prev_col = bus.adj_col;
  end

  // Reference model: sweep u ascending, groups of L columns; each group uses
  // dist[u] as it stood before that group.
  longint md [N];
  int     mp [N];
  bit     mneg;
  int     mnode;
  int     msweeps;

  function automatic longint sat(input longint s);
    if (s > INF - 1) return INF - 1;
    if (s < MINV)    return MINV;
    return s;
  endfunction

  task automatic model(input int s);
    bit any, stop;
    longint du, t;
    for (int i = 0; i < N; i++) begin md[i] = INF; mp[i] = 0; end
    md[s] = 0; mneg = 0; mnode = 0; msweeps = 0; stop = 0;
    for (int p = 0; p < N - 1 && !stop; p++) begin
      any = 0;
      msweeps++;
      for (int u = 0; u < N; u++)
        for (int g = 0; g < N; g += L) begin
          du = md[u];
          for (int k = 0; k < L; k++) begin
            if (du != INF && adj[u][g+k] != INF) begin
              t = sat(du + adj[u][g+k]);
              if (t < md[g+k]) begin md[g+k] = t; mp[g+k] = u; any = 1; end
            end
          end
        end
      if (EARLY && !any) stop = 1;
    end
    if (!stop) begin
      msweeps++;
      for (int u = 0; u < N; u++)
        for (int v = 0; v < N; v++)
          if (!mneg && md[u] != INF && adj[u][v] != INF && sat(md[u] + adj[u][v]) < md[v]) begin
            mneg = 1; mnode = v;
          end
    end
  endtask

  task automatic clear_graph();
    for (int u = 0; u < N; u++)
      for (int v = 0; v < N; v++) adj[u][v] = INF;
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_neg"}, bus.neg_cycle, 0);
    check_val({tag, "_rden"}, bus.adj_rd_en, 0);
    for (int i = 0; i < N; i++) begin
      bus.dist_rd_addr = IDX'(i);
      #1;
      check_val($sformatf("%s_dist%0d", tag, i), bus.dist_rd_data, INF);
      check_val($sformatf("%s_pred%0d", tag, i), bus.pred_rd_data, 0);
    end
  endtask

  task automatic run_case(input string tag, input int s);
    int cyc;
    bit fin;
    model(s);
    @(negedge clk);
    bus.src   = IDX'(s);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check_val({tag, "_busy_hi"}, bus.busy, 1);
    check_val({tag, "_done_lo"}, bus.done, 0);
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 5) begin
        bus.start = 1'b1;            // ignored: engine is busy
        bus.src   = IDX'(s ^ 1);
      end else bus.start = 1'b0;
      if (bus.done) fin = 1;
    end
    check_val({tag, "_done"}, bus.done, 1);
    check_val({tag, "_latency"}, cyc, 1 + msweeps * (N * N / L + 1));
    check_val({tag, "_busy_lo"}, bus.busy, 0);
    check_val({tag, "_neg"}, bus.neg_cycle, mneg);
    if (mneg) check_val({tag, "_negnode"}, bus.neg_node, mnode);
    for (int i = 0; i < N; i++) begin
      bus.dist_rd_addr = IDX'(i);
      #1;
      check_val($sformatf("%s_dist%0d", tag, i), bus.dist_rd_data, md[i]);
      check_val($sformatf("%s_pred%0d", tag, i), bus.pred_rd_data, mp[i]);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.src = '0;
    bus.dist_rd_addr = '0;
    bus.adj_rd_data = '0;
    clear_graph();
    repeat (3) @(posedge clk);
    #1 check_cleared("por");
    @(negedge clk) reset = 1'b0;

    // Chain 0->1->2->3.
    clear_graph();
    adj[0][1] = 5; adj[1][2] = -3; adj[2][3] = 4;
    run_case("chain", 0);

    // Reset mid-sweep, then rerun.
    @(negedge clk);
    bus.src = '0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_cleared("midrst");
    @(posedge clk);
    #3 reset = 1'b0;
    run_case("chain_after_rst", 0);

    // Negative cycle 1<->2.
    clear_graph();
    adj[0][1] = 3; adj[1][2] = -2; adj[2][1] = 1;
    run_case("negcyc", 0);

    // Vertex 3 unreachable with a strongly negative outgoing edge.
    clear_graph();
    adj[0][1] = 2; adj[1][2] = 2; adj[2][0] = 7; adj[3][0] = -100;
    run_case("unreach", 0);

    // Saturation at signed minimum.
    clear_graph();
    adj[0][1] = MINV + 1; adj[1][2] = -10;
    run_case("sat", 0);

    // Random graphs, random sources.
    for (int t = 0; t < 24; t++) begin
      clear_graph();
      for (int u = 0; u < N; u++)
        for (int v = 0; v < N; v++)
          if ($urandom_range(0, 99) < 40) adj[u][v] = longint'($urandom_range(0, 50)) - 12;
      if ($urandom_range(0, 7) == 0) adj[$urandom_range(0, N-1)][$urandom_range(0, N-1)] = MINV + 5;
      run_case($sformatf("rnd%0d", t), int'($urandom_range(0, N - 1)));
    end

    check_val("addr_hold", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bellman_ford_engine.md
Name: bellman_ford_engine

Overview:
- Parametrised successor to the single-source shortest-path relaxation engine in the arbitrage datapath.
- Runs Bellman-Ford over an NODES x NODES weight matrix, where weights are scaled -log(rate).
- Reads the matrix through a narrow memory port, LANES edges per cycle, instead of a full-matrix port.
- Adds a negative-cycle check pass (arbitrage detect), predecessor tracking, a start/busy/done handshake and a distance readout port.

Parameters:
- NODES, 16: vertex count; must be a multiple of LANES.
- LANES, 4: edges relaxed per cycle.
- WEIGHT_W, 32: signed weight/distance width.
- IDX_W, $clog2(NODES): vertex index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  start request; accepted only in IDLE or DONE
- src  in  IDX_W  source vertex; sampled when start is accepted
- adj_rd_en  out  1  matrix read strobe
- adj_row  out  IDX_W  row u (from-vertex)
- adj_col  out  IDX_W  base column v0; always a multiple of LANES
- adj_rd_data  in  LANES*WEIGHT_W  weights adj[u][v0+k], lane k at bits [k*WEIGHT_W +: WEIGHT_W]; valid 1 cycle after adj_rd_en
- dist_rd_addr  in  IDX_W  distance/pred readout address
- dist_rd_data  out  WEIGHT_W  dist[dist_rd_addr], combinational
- pred_rd_data  out  IDX_W  pred[dist_rd_addr], combinational
- busy  out  1  high from start acceptance until DONE
- done  out  1  level; high in DONE
- neg_cycle  out  1  negative cycle reachable from src; valid while done
- neg_node  out  IDX_W  first vertex found relaxable in the check pass; valid while done

Behaviour:
- INF = max positive signed WEIGHT_W value. An adjacency entry equal to INF means no edge.
- Reset (async, any state, including mid-run):
  - state is IDLE.
  - busy, done, neg_cycle and adj_rd_en are 0; neg_node is 0.
  - every dist is INF; every pred is 0.
- States: IDLE -> INIT -> RELAX -> CHECK -> DONE.
- IDLE/DONE:
  - start=1 latches src and goes to INIT.
  - done falls and busy rises on the cycle after start.
- INIT (1 cycle):
  - dist[src]=0; every other dist = INF; all pred = 0; pass counter = 0.
- RELAX sweep order:
  - for u = 0..NODES-1, for v0 = 0, LANES, .., NODES-LANES.
  - One read is issued per cycle, so a sweep takes NODES*NODES/LANES issue cycles plus 1 drain cycle.
- Relax stage (cycle after the read):
  - For each lane k with v = v0+k and w = lane k:
  - relax if dist[u] != INF, w != INF, and sat(dist[u]+w) < dist[v].
  - On relax: dist[v] <= sat(sum), pred[v] <= u.
  - dist[u] is read from the register in the relax cycle, not the issue cycle; updates written in the previous cycle are visible.
- Arithmetic:
  - sum is computed in WEIGHT_W+1 bits.
  - sat() clamps to [signed min, INF-1], so a relaxed distance never equals INF and never wraps.
- Multiple lanes updating distinct v in one cycle: all writes commit. Lanes never share v within a cycle.
- A self-loop (u==v) with negative weight relaxes dist[u]; the new value is visible next cycle.
- After NODES-1 sweeps: go to CHECK.
- CHECK:
  - Identical sweep with no dist/pred writes.
  - The first relaxable lane in scan order (lowest u, then lowest k) sets neg_cycle=1 and neg_node=v.
  - Later hits are ignored.
- After the CHECK drain cycle: DONE. done=1, busy=0.
- start while busy is ignored, with no effect on progress.
- The adj read address is held stable whenever adj_rd_en=0.
- Latency without the optional feature: 1 + NODES*(NODES*NODES/LANES + 1) cycles from start acceptance to done.

Optional Feature:
- Macro: BF_EARLY_EXIT_EN.
- Defined:
  - A per-sweep flag records whether any relax occurred.
  - A RELAX sweep with zero updates skips the remaining sweeps and CHECK, then goes directly to DONE with neg_cycle=0.
  - Results are identical to the undefined case; only cycle count differs.
- Undefined: always exactly NODES-1 relax sweeps plus CHECK.

Decomposition:
- Package bf_pkg:
  - state enum
  - INF constant function of WEIGHT_W
  - sat_add function
- Sub-module bf_relax_lane, instantiated LANES times:
  - inputs du, w, dv
  - outputs relax flag and the saturated new distance
  - combinational

Test Plan:
1. Reset: assert reset mid-sweep -> busy=0, done=0, all dist_rd_data=INF; a following start produces correct results.
2. NODES=4, LANES=2, edges 0->1 w=5, 1->2 w=-3, 2->3 w=4, src=0 -> dist={0,5,2,6}, pred={0,0,1,2}, neg_cycle=0, done exactly 1+4*(8+1)=37 cycles after start (macro off).
3. NODES=4, LANES=2, edges 0->1 w=3, 1->2 w=-2, 2->1 w=1, src=0 -> neg_cycle=1, neg_node=2.
4. Vertex 3 unreachable, with edge 3->0 w=-100 -> dist[3]=INF, dist[0]=0, no relax through 3, neg_cycle=0.
5. Saturation: src=0, 0->1 w=signed min+1, 1->2 w=-10 -> dist[2]=signed min (clamped, no wrap).
6. BF_EARLY_EXIT_EN with graph from test 2 -> same dist; done after second zero-update sweep, earlier than 37 cycles. A start pulse during busy is ignored.
